// File: rtl/servant_ram_arbiter.sv
// servant_ram_arbiter: shares one single-port Wishbone RAM between the
// instruction-fetch bus (ibus) and the data bus (dbus) of the core.
// One transfer at a time; the losing request stays pending until served.
// Build option: define SERVANT_ARB_ROUNDROBIN_EN to alternate grants on a
// tie. Without it, dbus always wins a tie.
module servant_ram_arbiter #(
   parameter int aw = 8
) (
   input  logic          i_wb_clk,
   input  logic          i_wb_rst,
   input  logic [31:0]   i_ibus_adr,
   input  logic          i_ibus_cyc,
   output logic [31:0]   o_ibus_rdt,
   output logic          o_ibus_ack,
   input  logic [31:0]   i_dbus_adr,
   input  logic [31:0]   i_dbus_dat,
   input  logic [3:0]    i_dbus_sel,
   input  logic          i_dbus_we,
   input  logic          i_dbus_cyc,
   output logic [31:0]   o_dbus_rdt,
   output logic          o_dbus_ack,
   output logic [aw-1:2] o_wb_adr,
   output logic [31:0]   o_wb_dat,
   output logic [3:0]    o_wb_sel,
   output logic          o_wb_we,
   output logic          o_wb_cyc,
   input  logic [31:0]   i_wb_rdt,
   input  logic          i_wb_ack
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      IBUS = 2'd1,
      DBUS = 2'd2
   } state_t;

   state_t state;
   logic   tie_to_ibus;

`ifdef SERVANT_ARB_ROUNDROBIN_EN
   // last_grant: 1 = dbus was granted last, 0 = ibus was granted last
   logic last_grant;
   assign tie_to_ibus = last_grant;
`else
   assign tie_to_ibus = 1'b0;
`endif

   // Grant / completion / abort state machine
   always_ff @(posedge i_wb_clk) begin
      if (i_wb_rst) begin
         state <= IDLE;
`ifdef SERVANT_ARB_ROUNDROBIN_EN
         last_grant <= 1'b1;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (i_ibus_cyc && (!i_dbus_cyc || tie_to_ibus)) begin
                  state <= IBUS;
`ifdef SERVANT_ARB_ROUNDROBIN_EN
                  last_grant <= 1'b0;
`endif
               end else if (i_dbus_cyc) begin
                  state <= DBUS;
`ifdef SERVANT_ARB_ROUNDROBIN_EN
                  last_grant <= 1'b1;
`endif
               end
            end
            IBUS: begin
               if (i_wb_ack || !i_ibus_cyc) state <= IDLE;
            end
            DBUS: begin
               if (i_wb_ack || !i_dbus_cyc) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // RAM-side request decoded from the current grant
   always_comb begin
      o_wb_cyc = 1'b0;
      o_wb_we  = 1'b0;
      o_wb_sel = 4'h0;
      o_wb_dat = 32'h0;
      o_wb_adr = '0;
      case (state)
         IBUS: begin
            o_wb_cyc = 1'b1;
            o_wb_sel = 4'hf;
            o_wb_adr = i_ibus_adr[aw-1:2];
         end
         DBUS: begin
            o_wb_cyc = 1'b1;
            o_wb_we  = i_dbus_we;
            o_wb_sel = i_dbus_sel;
            o_wb_dat = i_dbus_dat;
            o_wb_adr = i_dbus_adr[aw-1:2];
         end
         default: ;
      endcase
   end

   // Acks go only to the granted master; stale acks after abort/reset are dropped
   assign o_ibus_ack = i_wb_ack & (state == IBUS);
   assign o_dbus_ack = i_wb_ack & (state == DBUS);
   assign o_ibus_rdt = i_wb_rdt;
   assign o_dbus_rdt = i_wb_rdt;

   // Address bits outside the RAM window are intentionally ignored
   logic unused_adr;
   assign unused_adr = ^{i_ibus_adr[31:aw], i_ibus_adr[1:0],
                         i_dbus_adr[31:aw], i_dbus_adr[1:0]};

endmodule

// File: tb/tb_servant_ram_arbiter.sv
// Directed bench for servant_ram_arbiter with a one-cycle-latency RAM model.
module tb_servant_ram_arbiter;

`ifdef SERVANT_ARB_ROUNDROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ibus_adr, ibus_rdt, dbus_adr, dbus_dat, dbus_rdt;
   logic        ibus_cyc, ibus_ack, dbus_we, dbus_cyc, dbus_ack;
   logic [3:0]  dbus_sel, wb_sel;
   logic [7:2]  wb_adr;
   logic [31:0] wb_dat, wb_rdt;
   logic        wb_we, wb_cyc, wb_ack;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem [0:63];

   always #5 clk = ~clk;

   servant_ram_arbiter #(.aw(8)) dut (
      .i_wb_clk  (clk),
      .i_wb_rst  (rst),
      .i_ibus_adr(ibus_adr),
      .i_ibus_cyc(ibus_cyc),
      .o_ibus_rdt(ibus_rdt),
      .o_ibus_ack(ibus_ack),
      .i_dbus_adr(dbus_adr),
      .i_dbus_dat(dbus_dat),
      .i_dbus_sel(dbus_sel),
      .i_dbus_we (dbus_we),
      .i_dbus_cyc(dbus_cyc),
      .o_dbus_rdt(dbus_rdt),
      .o_dbus_ack(dbus_ack),
      .o_wb_adr  (wb_adr),
      .o_wb_dat  (wb_dat),
      .o_wb_sel  (wb_sel),
      .o_wb_we   (wb_we),
      .o_wb_cyc  (wb_cyc),
      .i_wb_rdt  (wb_rdt),
      .i_wb_ack  (wb_ack)
   );

   // RAM model: ack one cycle after cyc rises, byte-masked write on the first cycle
   always_ff @(posedge clk) begin
      wb_ack <= wb_cyc & ~wb_ack;
      wb_rdt <= mem[wb_adr];
      if (wb_cyc && wb_we && !wb_ack) begin
         for (int b = 0; b < 4; b++)
            if (wb_sel[b]) mem[wb_adr][8*b +: 8] <= wb_dat[8*b +: 8];
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   int ia_cnt, da_cnt, first_cyc, second_cyc, both_cnt, nacks;
   logic first_is_ibus;

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + 32'(i);
      wb_ack = 1'b0;
      ibus_adr = 32'h0; ibus_cyc = 1'b0;
      dbus_adr = 32'h0; dbus_dat = 32'h0; dbus_sel = 4'h0;
      dbus_we = 1'b0; dbus_cyc = 1'b0;

      // Reset state
      do_reset();
      check("rst_cyc", 32'(wb_cyc), 32'h0);
      check("rst_wb", {20'h0, 2'b0, wb_adr, wb_sel}, 32'h0);
      check("rst_we_dat", {31'h0, wb_we} | wb_dat, 32'h0);
      check("rst_acks", {30'h0, ibus_ack, dbus_ack}, 32'h0);

      // Single ibus read
      ibus_adr = 32'h10; ibus_cyc = 1'b1;
      tick();
      check("ird_cyc", 32'(wb_cyc), 32'h1);
      check("ird_adr", 32'(wb_adr), 32'h4);
      check("ird_sel_we", {27'h0, wb_sel, wb_we}, {27'h0, 4'hf, 1'b0});
      check("ird_dat", wb_dat, 32'h0);
      check("ird_noack", 32'(ibus_ack), 32'h0);
      tick();
      check("ird_ack", 32'(ibus_ack), 32'h1);
      check("ird_rdt", ibus_rdt, 32'h1000_0004);
      check("ird_dack", 32'(dbus_ack), 32'h0);
      ibus_cyc = 1'b0;
      tick();
      check("ird_idle", {30'h0, wb_cyc, ibus_ack}, 32'h0);

      // Dbus partial write
      dbus_adr = 32'h20; dbus_dat = 32'hA5A5_1234; dbus_sel = 4'b0011;
      dbus_we = 1'b1; dbus_cyc = 1'b1;
      tick();
      check("dwr_cyc_we", {30'h0, wb_cyc, wb_we}, 32'h3);
      check("dwr_sel", 32'(wb_sel), 32'h3);
      check("dwr_adr", 32'(wb_adr), 32'h8);
      check("dwr_dat", wb_dat, 32'hA5A5_1234);
      tick();
      check("dwr_ack", {30'h0, ibus_ack, dbus_ack}, 32'h1);
      dbus_cyc = 1'b0; dbus_we = 1'b0;
      tick();
      check("dwr_idle", {30'h0, wb_cyc, dbus_ack}, 32'h0);
      check("dwr_mem", mem[8], 32'h1000_1234);

      // Tie out of reset, each master drops cyc on its ack
      do_reset();
      ibus_adr = 32'h10; dbus_adr = 32'h24; dbus_sel = 4'hf;
      ibus_cyc = 1'b1; dbus_cyc = 1'b1;
      ia_cnt = 0; da_cnt = 0; first_cyc = -1; second_cyc = -1; both_cnt = 0;
      first_is_ibus = 1'b0;
      for (int c = 1; c <= 9; c++) begin
         tick();
         if (ibus_ack && dbus_ack) both_cnt++;
         if (ibus_ack || dbus_ack) begin
            if (first_cyc < 0) begin
               first_cyc = c;
               first_is_ibus = ibus_ack;
            end else begin
               second_cyc = c;
            end
         end
         if (ibus_ack) begin ia_cnt++; ibus_cyc = 1'b0; end
         if (dbus_ack) begin da_cnt++; dbus_cyc = 1'b0; end
      end
      check("tie_first", 32'(first_is_ibus), 32'(RR));
      check("tie_iack_cnt", 32'(ia_cnt), 32'h1);
      check("tie_dack_cnt", 32'(da_cnt), 32'h1);
      check("tie_first_cyc", 32'(first_cyc), 32'd2);
      check("tie_second_cyc", 32'(second_cyc), 32'd5);
      check("tie_both", 32'(both_cnt), 32'h0);

      // Continuous contention: alternation with RR, dbus starvation of ibus without
      do_reset();
      ibus_cyc = 1'b1; dbus_cyc = 1'b1; dbus_we = 1'b0;
      nacks = 0; both_cnt = 0;
      for (int c = 1; c <= 24; c++) begin
         tick();
         if (ibus_ack && dbus_ack) both_cnt++;
         if (ibus_ack || dbus_ack) begin
            check($sformatf("cont_grant%0d", nacks), 32'(ibus_ack),
                  32'(RR && (nacks % 2 == 0)));
            nacks++;
         end
      end
      check("cont_nacks", 32'(nacks), 32'd8);
      check("cont_both", 32'(both_cnt), 32'h0);
      ibus_cyc = 1'b0; dbus_cyc = 1'b0;

      // Reset in the cycle dbus is granted
      do_reset();
      dbus_cyc = 1'b1; dbus_adr = 32'h28;
      tick();
      check("rmid_granted", 32'(wb_cyc), 32'h1);
      rst = 1'b1;
      tick();
      rst = 1'b0; dbus_cyc = 1'b0;
      check("rmid_ram_ack", 32'(wb_ack), 32'h1);
      check("rmid_cyc", 32'(wb_cyc), 32'h0);
      check("rmid_dack", 32'(dbus_ack), 32'h0);
      check("rmid_wb", {22'h0, wb_adr, wb_sel}, 32'h0);
      tick();
      check("rmid_idle", {30'h0, wb_cyc, dbus_ack}, 32'h0);

      // Ibus abort before ack; late RAM ack masked
      ibus_adr = 32'h10; ibus_cyc = 1'b1;
      tick();
      check("abt_granted", 32'(wb_cyc), 32'h1);
      ibus_cyc = 1'b0;
      tick();
      check("abt_ram_ack", 32'(wb_ack), 32'h1);
      check("abt_iack", 32'(ibus_ack), 32'h0);
      check("abt_idle", 32'(wb_cyc), 32'h0);
      tick();
      check("abt_quiet", {30'h0, ibus_ack, dbus_ack}, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/servant_ram_arbiter.md
SERVANT_RAM_ARBITER -- requirements
Module: servant_ram_arbiter

Interface
REQ-001 SHALL have parameter: aw, 8, RAM byte-address width; the RAM word address is [aw-1:2].
REQ-002 SHALL have ports, clock and reset first:
  i_wb_clk      in   1       single clock; all logic on rising edge
  i_wb_rst      in   1       reset, synchronous, active-high
  i_ibus_adr    in   32      instruction-fetch byte address
  i_ibus_cyc    in   1       instruction request
  o_ibus_rdt    out  32      instruction read data
  o_ibus_ack    out  1       instruction ack
  i_dbus_adr    in   32      data byte address
  i_dbus_dat    in   32      data write data
  i_dbus_sel    in   4       data byte enables
  i_dbus_we     in   1       data write enable
  i_dbus_cyc    in   1       data request
  o_dbus_rdt    out  32      data read data
  o_dbus_ack    out  1       data ack
  o_wb_adr      out  aw-2    RAM word address [aw-1:2]
  o_wb_dat      out  32      RAM write data
  o_wb_sel      out  4       RAM byte enables
  o_wb_we       out  1       RAM write enable
  o_wb_cyc      out  1       RAM cycle
  i_wb_rdt      in   32      RAM read data
  i_wb_ack      in   1       RAM ack, one cycle after o_wb_cyc rises

Function
REQ-003 SHALL implement a registered FSM with states IDLE, IBUS, DBUS.
REQ-004 In IDLE, SHALL go to IBUS if only i_ibus_cyc is high, to DBUS if only i_dbus_cyc is high, and stay in IDLE if neither is high.
REQ-005 In IDLE with both requests high, SHALL choose the winner as REQ-016/017 define.
REQ-006 In IBUS/DBUS, o_wb_cyc SHALL be 1, and o_wb_adr SHALL be the granted master's adr[aw-1:2].
REQ-007 In IBUS: o_wb_we=0, o_wb_sel=4'hf, o_wb_dat=0. In DBUS: we/sel/dat SHALL pass through from dbus.
REQ-008 In IDLE: o_wb_cyc=0, o_wb_we=0, o_wb_sel=0, o_wb_dat=0, o_wb_adr=0.
REQ-009 o_ibus_ack SHALL equal i_wb_ack & (state==IBUS), and o_dbus_ack SHALL equal i_wb_ack & (state==DBUS), both combinational.
REQ-010 o_ibus_rdt and o_dbus_rdt SHALL both equal i_wb_rdt combinationally; the rdt value is valid only with that master's ack.
REQ-011 On a cycle with i_wb_ack high in IBUS/DBUS, SHALL return to IDLE on the next edge.
REQ-012 Latency: cyc sampled in IDLE at edge N; o_wb_cyc high in cycle N+1; master ack in cycle N+2; IDLE in cycle N+3.
REQ-013 Masters SHALL deassert cyc in the cycle after their ack; the arbiter SHALL NOT check for this.
REQ-014 Abort: if the granted master's cyc is low in IBUS/DBUS without i_wb_ack, SHALL go to IDLE next edge; any later RAM ack SHALL be masked by REQ-009.
REQ-015 The non-granted master's request SHALL be held pending and SHALL NOT be dropped; it is served from IDLE after the current transfer.

Reset
REQ-018 While i_wb_rst is high at an edge: state=IDLE and last_grant=DBUS.
REQ-019 In the cycle after reset, all o_wb_* outputs SHALL be 0 and both acks SHALL be 0, including when reset hits mid-transfer.
REQ-020 A RAM ack arriving after reset SHALL NOT be forwarded.

Configuration
REQ-016 With macro SERVANT_ARB_ROUNDROBIN_EN defined, SHALL keep a 1-bit last_grant register updated on every grant, and SHALL give a tie in IDLE to the master not in last_grant.
REQ-017 Without SERVANT_ARB_ROUNDROBIN_EN, SHALL give a tie to DBUS (fixed priority); the last_grant register SHALL NOT be built.

Verification
REQ-021 Single ibus read: ibus_cyc=1, adr=0x10 -> o_wb_adr=0x04 one cycle later, o_ibus_ack one cycle after that with rdt=RAM word 4, and o_dbus_ack stays 0.
REQ-022 Dbus write: cyc=1, we=1, sel=4'b0011, dat=0xA5A5_1234, adr=0x20 -> o_wb_we=1, sel=0011, adr=0x08; RAM bytes 0-1 of word 8 become 0x1234; dbus_ack once.
REQ-023 Both masters request out of reset, held until acked -> RR build: ibus served then dbus; fixed build: dbus then ibus; each ack exactly once, 3 cycles apart.
REQ-024 Both masters request continuously for 8 transfers (RR build) -> grants alternate I,D,I,D...; no cycle with both acks high.
REQ-025 Reset asserted in the cycle when DBUS is granted -> next cycle o_wb_cyc=0, no dbus ack, state IDLE.
REQ-026 ibus_cyc dropped after grant and before ack -> IDLE next edge; the RAM ack is masked (o_ibus_ack=0).
